// File: rtl/hack_mmio_memory.sv
// Hack data-memory map: block-RAM window, MMIO output registers with readback,
// synchronised MMIO inputs with sticky rising-edge flags (W1C) and an interrupt line.
module hack_mmio_memory #(
    parameter int                DATA_W  = 16,
    parameter int                RAM_AW  = 14,
    parameter int                NUM_OUT = 4,
    parameter int                NUM_IN  = 2,
    parameter logic [DATA_W-1:0] OUT_RST = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         in,
    input  logic [15:0]               address,
    input  logic                      load,
    output logic [DATA_W-1:0]         out,
    output logic [NUM_OUT*DATA_W-1:0] mmio_out,
    input  logic [NUM_IN*DATA_W-1:0]  mmio_in,
    output logic                      irq
);

    localparam int RAM_DEPTH = 1 << RAM_AW;

    logic [3:0]               w_idx;
    logic                     w_ram_sel;
    logic                     w_out_page;
    logic                     w_in_page;
    logic                     w_edge_page;
    logic [NUM_IN*DATA_W-1:0] w_clr;
    logic [NUM_IN*DATA_W-1:0] w_rise;
    logic [DATA_W-1:0]        w_rd_data;

    logic [DATA_W-1:0]         r_ram [RAM_DEPTH];
    logic [DATA_W-1:0]         r_ram_q;
    logic [NUM_OUT*DATA_W-1:0] r_out;
    logic [NUM_IN*DATA_W-1:0]  r_sync1;
    logic [NUM_IN*DATA_W-1:0]  r_sync2;
    logic [NUM_IN*DATA_W-1:0]  r_prev;
    logic [NUM_IN*DATA_W-1:0]  r_sticky;
    logic                      r_irq;
    logic                      r_rd_ram;
    logic [DATA_W-1:0]         r_rd_mmio;

    // Index field is only meaningful together with the full page compare.
    assign w_idx       = address[3:0];
    assign w_ram_sel   = (32'(address) >> RAM_AW) == 32'd0;
    assign w_out_page  = address[15:4] == 12'h400;
    assign w_in_page   = address[15:4] == 12'h401;
    assign w_edge_page = address[15:4] == 12'h402;
    assign w_rise      = r_sync2 & ~r_prev;

    // NOTE: the RAM array has no reset so it maps onto a block RAM; the
    // non-blocking read alongside the write gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (load && w_ram_sel)
            r_ram[address[RAM_AW-1:0]] <= in;
        r_ram_q <= r_ram[address[RAM_AW-1:0]];
    end

    // NOTE: every variable driven here gets a default first, so no latch is inferred.
    always_comb begin
        w_clr     = '0;
        w_rd_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (load && w_edge_page && w_idx == 4'(i))
                w_clr[i*DATA_W +: DATA_W] = in;
            if (w_in_page && w_idx == 4'(i))
                w_rd_data = r_sync2[i*DATA_W +: DATA_W];
            if (w_edge_page && w_idx == 4'(i))
                w_rd_data = r_sticky[i*DATA_W +: DATA_W];
        end
        for (int i = 0; i < NUM_OUT; i++) begin
            if (w_out_page && w_idx == 4'(i))
                w_rd_data = r_out[i*DATA_W +: DATA_W];
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= {NUM_OUT{OUT_RST}};
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (load && w_out_page && w_idx == 4'(i))
                    r_out[i*DATA_W +: DATA_W] <= in;
            end
        end
    end

    // Set wins over a same-cycle clear: the rise is ORed in after masking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_sticky <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_sync1  <= mmio_in;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_sticky <= (r_sticky & ~w_clr) | w_rise;
            r_irq    <= |r_sticky;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ram  <= 1'b0;
            r_rd_mmio <= '0;
        end else begin
            r_rd_ram  <= w_ram_sel;
            r_rd_mmio <= w_rd_data;
        end
    end

    // Final select is driven purely by registers, never by address.
    assign out      = r_rd_ram ? r_ram_q : r_rd_mmio;
    assign mmio_out = r_out;
    assign irq      = r_irq;

endmodule

// File: tb/tb_hack_mmio_memory.sv
// Directed self-checking bench for hack_mmio_memory: RAM, MMIO outputs,
// synchronised inputs, sticky W1C edge flags, irq and asynchronous reset.
module tb_hack_mmio_memory;

    localparam int          DATA_W  = 16;
    localparam int          NUM_OUT = 4;
    localparam int          NUM_IN  = 2;
    localparam logic [15:0] RST_V   = 16'h5A00;

    logic                      clk;
    logic                      rst_n;
    logic [DATA_W-1:0]         in;
    logic [15:0]               address;
    logic                      load;
    logic [DATA_W-1:0]         out;
    logic [NUM_OUT*DATA_W-1:0] mmio_out;
    logic [NUM_IN*DATA_W-1:0]  mmio_in;
    logic                      irq;

    int n_checks = 0;
    int n_fail   = 0;

    hack_mmio_memory #(
        .DATA_W (DATA_W),
        .RAM_AW (14),
        .NUM_OUT(NUM_OUT),
        .NUM_IN (NUM_IN),
        .OUT_RST(RST_V)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in),
        .address (address),
        .load    (load),
        .out     (out),
        .mmio_out(mmio_out),
        .mmio_in (mmio_in),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        address = a;
        in      = d;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
        address = a;
        load    = 1'b0;
        tick();
        check(tag, {48'b0, out}, {48'b0, exp});
    endtask

    initial begin
        rst_n   = 1'b1;
        load    = 1'b0;
        in      = '0;
        address = 16'h7FFF;
        mmio_in = '0;

        // Reset asserted mid-cycle, checked before and after release.
        #3 rst_n = 1'b0;
        #1;
        check("rst_out", {48'b0, out}, 64'h0);
        check("rst_mmio_out", mmio_out, {RST_V, RST_V, RST_V, RST_V});
        check("rst_irq", {63'b0, irq}, 64'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_out", {48'b0, out}, 64'h0);
        check("post_rst_irq", {63'b0, irq}, 64'h0);

        // RAM write then read with one-cycle latency.
        wr(16'h0005, 16'h1234);
        address = 16'h7FFF;
        tick();
        address = 16'h0005;
        #1 check("ram_rd_not_yet", {48'b0, out}, 64'h0);
        tick();
        check("ram_rd_5", {48'b0, out}, 64'h1234);

        // MMIO outputs, readback and out-of-range index.
        wr(16'h4000, 16'hA5A5);
        wr(16'h4003, 16'h00FF);
        check("mmio_ch0", {48'b0, mmio_out[15:0]}, 64'hA5A5);
        check("mmio_ch3", {48'b0, mmio_out[63:48]}, 64'h00FF);
        check("mmio_ch1_rst", {48'b0, mmio_out[31:16]}, {48'b0, RST_V});
        rd("rb_4003", 16'h4003, 16'h00FF);
        rd("rb_4000", 16'h4000, 16'hA5A5);
        wr(16'h4004, 16'hBEEF);
        check("mmio_no_wrap", mmio_out, {16'h00FF, RST_V, RST_V, 16'hA5A5});
        rd("rd_4004", 16'h4004, 16'h0000);
        rd("rd_4012", 16'h4012, 16'h0000);
        rd("rd_4022", 16'h4022, 16'h0000);
        rd("rd_6000", 16'h6000, 16'h0000);

        // Read-during-write, RAM then MMIO: pre-write data is returned.
        wr(16'h0007, 16'h1111);
        address = 16'h0007;
        in      = 16'h2222;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        check("rdw_ram_old", {48'b0, out}, 64'h1111);
        tick();
        check("rdw_ram_new", {48'b0, out}, 64'h2222);
        address = 16'h4001;
        in      = 16'h5555;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        check("rdw_mmio_old", {48'b0, out}, {48'b0, RST_V});
        tick();
        check("rdw_mmio_new", {48'b0, out}, 64'h5555);
        check("mmio_ch1_new", {48'b0, mmio_out[31:16]}, 64'h5555);

        // Input ch1 rises to 0x0009: IN visible after 3 edges, irq one later.
        mmio_in[31:16] = 16'h0009;
        address = 16'h4011;
        tick();
        check("in1_p1", {48'b0, out}, 64'h0);
        tick();
        check("in1_p2", {48'b0, out}, 64'h0);
        tick();
        check("in1_p3", {48'b0, out}, 64'h0009);
        check("irq_p3", {63'b0, irq}, 64'h0);
        address = 16'h4021;
        tick();
        check("edge1_p4", {48'b0, out}, 64'h0009);
        check("irq_p4", {63'b0, irq}, 64'h1);
        mmio_in[31:16] = 16'h0000;
        repeat (4) tick();
        rd("edge1_sticky", 16'h4021, 16'h0009);
        rd("in1_zero", 16'h4011, 16'h0000);

        // W1C behaviour and read-only IN register.
        wr(16'h4021, 16'h0001);
        rd("edge1_w1c1", 16'h4021, 16'h0008);
        check("irq_still", {63'b0, irq}, 64'h1);
        wr(16'h4021, 16'h0008);
        check("irq_lag", {63'b0, irq}, 64'h1);
        rd("edge1_clear", 16'h4021, 16'h0000);
        check("irq_clear", {63'b0, irq}, 64'h0);
        mmio_in[31:16] = 16'h0030;
        repeat (4) tick();
        wr(16'h4011, 16'hFFFF);
        rd("in1_ro", 16'h4011, 16'h0030);
        rd("edge1_30", 16'h4021, 16'h0030);
        wr(16'h4021, 16'hFFFF);
        repeat (2) tick();
        check("irq_clear2", {63'b0, irq}, 64'h0);

        // Set wins: W1C of bit 2 lands on the edge where ch0 bit 2 rises.
        mmio_in[2] = 1'b1;
        tick();
        tick();
        address = 16'h4020;
        in      = 16'h0004;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        rd("set_wins", 16'h4020, 16'h0004);
        check("irq_set", {63'b0, irq}, 64'h1);

        // Asynchronous reset clears flags, irq and outputs without a clock edge.
        mmio_in = '0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_irq", {63'b0, irq}, 64'h0);
        check("arst_mmio_out", mmio_out, {RST_V, RST_V, RST_V, RST_V});
        check("arst_out", {48'b0, out}, 64'h0);
        tick();
        rst_n = 1'b1;
        rd("arst_edge0", 16'h4020, 16'h0000);
        rd("ram_kept", 16'h0005, 16'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hack_mmio_memory.md
Name: hack_mmio_memory

Overview:
- Parametrised successor to the Hack data-memory map: a RAM window plus a bank of MMIO output registers and synchronised, edge-capturing MMIO input channels.
- Sits between the Hack CPU data port and board I/O (LEDs, buttons, DIP switches).
- Adds the following to the single-LED map:
  - registered reads with fixed latency
  - multiple output channels with readback
  - input synchronisers
  - sticky rising-edge flags with write-1-to-clear
  - an aggregated interrupt line

Parameters:
DATA_W, 16, data word width
RAM_AW, 14, RAM address bits; RAM occupies word addresses 0 .. 2^RAM_AW-1
NUM_OUT, 4, number of MMIO output registers (1..16)
NUM_IN, 2, number of MMIO input channels (1..16)
OUT_RST, 0, reset value of every output register

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in  in  DATA_W  write data
address  in  16  word address
load  in  1  write strobe, sampled at posedge clk
out  out  DATA_W  read data, valid one cycle after address is presented
mmio_out  out  NUM_OUT*DATA_W  output registers; channel i at bits [i*DATA_W +: DATA_W]
mmio_in  in  NUM_IN*DATA_W  asynchronous input channels, same packing
irq  out  1  high while any sticky edge bit is set

Behaviour:
- Reset is asynchronous, active-low, and drives:
  - out = 0
  - every mmio_out channel = OUT_RST
  - synchroniser flops = 0
  - edge-history flops = 0
  - sticky flags = 0
  - irq = 0
- RAM contents are not reset.
- A write in progress when rst_n falls is dropped for MMIO registers; RAM behaviour for that cycle is undefined.
- Address decode:
  - RAM: address < 2^RAM_AW.
  - OUT[i]: 0x4000 + i, i < NUM_OUT; read/write.
  - IN[i]: 0x4010 + i, i < NUM_IN; read-only synchronised value. Writes are ignored.
  - EDGE[i]: 0x4020 + i, i < NUM_IN; sticky flags. A write clears the bits where in=1 (W1C).
  - Anything else: reads return 0, writes are ignored.
- Writes take effect at the posedge where load=1. A readback in a later cycle sees the new value.
- Reads:
  - out is registered. The address sampled at posedge N appears on out after posedge N and holds until posedge N+1. One-cycle latency for all regions.
  - RAM read-during-write to the same address returns the old data (read-first).
  - MMIO read-during-write to the same register returns the pre-write value.
  - Reads have no side effects.
- Input path, per bit:
  - two-flop synchroniser giving sync[i]
  - one history flop giving prev[i]
  - rise = sync & ~prev
  - sticky[i] <= (sticky[i] & ~clear_mask) | rise
  - A simultaneous rise and W1C on the same bit leaves the bit set (set wins).
  - Minimum latency from an mmio_in change to IN readback: 2 posedges for the synchronised value, then 1 more for out.
  - A sticky bit sets 3 posedges after the input rises.
- irq is registered: irq <= OR of all sticky bits of all channels. It lags sticky by one cycle.
- Widths:
  - The RAM index is address[RAM_AW-1:0].
  - MMIO index fields are address[3:0], qualified by the full upper-address compare.
  - No wrap-around: out-of-range indices, e.g. 0x4000+NUM_OUT, decode as unmapped.
- Synthesis:
  - The RAM is inferred as a single-port synchronous block RAM.
  - There are no combinational paths from address to out.

Test Plan:
- Reset with rst_n=0 mid-cycle, then release → out=0, all mmio_out=OUT_RST, irq=0. Write 0x1234 to 0x0005, then read 0x0005 → out=0x1234 exactly one cycle after the address is presented.
- Write 0xA5A5 to 0x4000 and 0x00FF to 0x4003 → mmio_out ch0=0xA5A5, ch3=0x00FF. Readback of 0x4003 returns 0x00FF. Write to 0x4004 (NUM_OUT=4) → no channel changes and a read returns 0.
- Read-during-write: RAM[7]=0x1111, then write 0x2222 to 0x0007 while reading it → out=0x1111 that cycle and 0x2222 on the next read. Write 0x5555 to 0x4001 while reading 0x4001 → out=pre-write value.
- mmio_in ch1 goes 0x0000→0x0009 → IN[1] read=0x0009 and EDGE[1]=0x0009 within 3 posedges, irq=1 one cycle after EDGE sets. Input returns to 0 → EDGE still 0x0009.
- W1C: write 0x0001 to 0x4021 → EDGE[1]=0x0008, irq stays 1. Write 0x0008 → EDGE[1]=0, irq=0 next cycle. Write 0xFFFF to 0x4011 → IN[1] unchanged.
- Set-wins: W1C of bit 2 on 0x4020 in the same cycle bit 2 of ch0 rises → bit 2 remains set. Assert rst_n=0 while flags and irq are set → all flags, irq and mmio_out clear immediately, without waiting for a clock edge.
